// File: rtl/truth_table_scanner.sv
// Stimulus/capture engine: walks every input combination onto a small combinational DUT,
// samples its output after a settle interval, and checks the captured minterm map.
module truth_table_scanner #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 y_in,
  output logic [N_IN-1:0]      in_vec,
  output logic [2**N_IN-1:0]   minterms,
  output logic [N_IN:0]        ones_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
);

  localparam int NCOMB = 1 << N_IN;
  localparam int CW    = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE_CYC);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   in_vec_q, in_vec_d;
  logic [NCOMB-1:0]  minterms_q, minterms_d;
  logic [N_IN:0]     ones_cnt_q, ones_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_vec_d   = in_vec_q;
    minterms_d = minterms_q;
    ones_cnt_d = ones_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          cnt_d      = CNT_INIT;
          in_vec_d   = '0;
          minterms_d = '0;
          ones_cnt_d = '0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d  = IDLE;
          in_vec_d = '0;
          busy_d   = 1'b0;
          pass_d   = 1'b0;
        end else if (cnt_q == CW'(1)) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SAMPLE: begin
        // Abort wins over the capture, so the partial map never holds the aborted combination.
        if (abort) begin
          state_d  = IDLE;
          in_vec_d = '0;
          busy_d   = 1'b0;
          pass_d   = 1'b0;
        end else begin
          minterms_d[in_vec_q] = y_in;
          ones_cnt_d           = ones_cnt_q + (N_IN+1)'(y_in);
          if (in_vec_q == VEC_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Early verdict so pass is already valid while done is high.
            pass_d  = (minterms_d == expected);
          end else begin
            state_d  = SETTLE;
            in_vec_d = in_vec_q + N_IN'(1);
            cnt_d    = CNT_INIT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        pass_d  = (minterms_q == expected);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_vec_q   <= '0;
      minterms_q <= '0;
      ones_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_vec_q   <= in_vec_d;
      minterms_q <= minterms_d;
      ones_cnt_q <= ones_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign in_vec   = in_vec_q;
  assign minterms = minterms_q;
  assign ones_cnt = ones_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized bench for truth_table_scanner: two instances (settle 1 and 3) scanning
// table-driven DUT models, checked against a scan-level reference model.
module tb_truth_table_scanner;
  localparam int N  = 3;
  localparam int NC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start_v, abort_v, sel;
  logic [NC-1:0] tbl_v, exp_v;

  logic          a_start, a_abort, a_y, a_busy, a_done, a_pass;
  logic [N-1:0]  a_in_vec;
  logic [NC-1:0] a_minterms;
  logic [N:0]    a_ones;
  logic          b_start, b_abort, b_y, b_busy, b_done, b_pass;
  logic [N-1:0]  b_in_vec;
  logic [NC-1:0] b_minterms;
  logic [N:0]    b_ones;

  assign a_start = start_v & ~sel;
  assign b_start = start_v & sel;
  assign a_abort = abort_v & ~sel;
  assign b_abort = abort_v & sel;
  assign a_y     = tbl_v[a_in_vec];
  assign b_y     = tbl_v[b_in_vec];

  truth_table_scanner u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .expected(exp_v),
    .y_in(a_y), .in_vec(a_in_vec), .minterms(a_minterms), .ones_cnt(a_ones),
    .busy(a_busy), .done(a_done), .pass(a_pass)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE_CYC(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .expected(exp_v),
    .y_in(b_y), .in_vec(b_in_vec), .minterms(b_minterms), .ones_cnt(b_ones),
    .busy(b_busy), .done(b_done), .pass(b_pass)
  );

  logic          v_busy, v_done, v_pass;
  logic [N-1:0]  v_in_vec;
  logic [NC-1:0] v_minterms;
  logic [N:0]    v_ones;
  assign v_busy     = sel ? b_busy     : a_busy;
  assign v_done     = sel ? b_done     : a_done;
  assign v_pass     = sel ? b_pass     : a_pass;
  assign v_in_vec   = sel ? b_in_vec   : a_in_vec;
  assign v_minterms = sel ? b_minterms : a_minterms;
  assign v_ones     = sel ? b_ones     : a_ones;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int settle_of(input logic s);
    return s ? 3 : 1;
  endfunction

  function automatic int ones_of(input logic [NC-1:0] m);
    int c = 0;
    for (int k = 0; k < NC; k++) if (m[k]) c++;
    return c;
  endfunction

  // Full scan: the map must equal the table, each combination occupies settle+1 clocks.
  task automatic scan(input logic s, input logic [NC-1:0] tbl, input logic [NC-1:0] ex,
                      input string tag);
    int cyc, st, vec_err, busy_err;
    bit seen;
    st = settle_of(s);
    @(negedge clk);
    sel = s; tbl_v = tbl; exp_v = ex; start_v = 1'b1;
    cyc = 0; seen = 0; vec_err = 0; busy_err = 0;
    while (!seen && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start_v = 1'b0;
      if (v_done === 1'b1) seen = 1;
      else begin
        if (v_busy !== 1'b1) busy_err++;
        if (int'(v_in_vec) != (cyc - 1) / (st + 1)) vec_err++;
      end
    end
    check({tag, ".done_cyc"}, cyc, NC * (st + 1) + 1);
    check({tag, ".minterms"}, v_minterms, tbl);
    check({tag, ".ones"}, v_ones, ones_of(tbl));
    check({tag, ".pass"}, v_pass, (tbl == ex));
    check({tag, ".in_vec_end"}, v_in_vec, NC - 1);
    check({tag, ".busy_end"}, v_busy, 0);
    check({tag, ".in_vec_seq_err"}, vec_err, 0);
    check({tag, ".busy_err"}, busy_err, 0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, v_done, 0);
    check({tag, ".pass_hold"}, v_pass, (tbl == ex));
    check({tag, ".minterms_hold"}, v_minterms, tbl);
  endtask

  // Abort while combination k is applied, 'extra' clocks into its settle/sample window.
  task automatic abort_scan(input logic s, input logic [NC-1:0] tbl, input int k,
                            input int extra, input string tag);
    int cyc, dseen, bseen;
    logic [NC-1:0] mask, part;
    @(negedge clk);
    sel = s; tbl_v = tbl; exp_v = tbl; start_v = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      start_v = 1'b0;
    end while (!(v_busy === 1'b1 && int'(v_in_vec) == k) && cyc < 400);
    check({tag, ".reach_k"}, (cyc < 400), 1);
    repeat (extra) begin @(posedge clk); #1; end
    @(negedge clk); abort_v = 1'b1;
    @(posedge clk); #1; abort_v = 1'b0;
    mask = (NC'(1) << k) - NC'(1);
    part = tbl & mask;
    check({tag, ".busy"}, v_busy, 0);
    check({tag, ".in_vec"}, v_in_vec, 0);
    check({tag, ".minterms"}, v_minterms, part);
    check({tag, ".ones"}, v_ones, ones_of(part));
    check({tag, ".pass"}, v_pass, 0);
    dseen = 0; bseen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (v_done !== 1'b0) dseen++;
      if (v_busy !== 1'b0) bseen++;
    end
    check({tag, ".no_done"}, dseen, 0);
    check({tag, ".stays_idle"}, bseen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, cyc;
    logic [NC-1:0] t, e;
    rst_n = 1'b0; start_v = 1'b0; abort_v = 1'b0; sel = 1'b0;
    tbl_v = '0; exp_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst.in_vec", a_in_vec, 0);
    check("rst.minterms", a_minterms, 0);
    check("rst.ones", a_ones, 0);
    check("rst.busy", a_busy, 0);
    check("rst.done", a_done, 0);
    check("rst.pass", a_pass, 0);

    // y = D & (~C | B) over {B,C,D}
    scan(1'b0, 8'hA2, 8'hA2, "t1");
    scan(1'b1, 8'hFF, 8'hFF, "t2");
    scan(1'b0, 8'hA2, 8'hA3, "t3");
    abort_scan(1'b0, 8'hA2, 4, 0, "t4");

    for (int i = 0; i < 8; i++) begin
      t = 8'($urandom);
      e = ($urandom_range(1) == 1) ? t : (t ^ (NC'(1) << $urandom_range(NC - 1)));
      scan(1'($urandom_range(1)), t, e, $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      logic s;
      s = 1'($urandom_range(1));
      abort_scan(s, 8'($urandom), $urandom_range(NC - 1, 1),
                 $urandom_range(settle_of(s)), $sformatf("rab%0d", i));
    end

    // Start held high: the second scan must follow the first DONE immediately.
    @(negedge clk);
    sel = 1'b0; tbl_v = 8'hA2; exp_v = 8'hA2; start_v = 1'b1;
    cyc = 0; d1 = 0; d2 = 0;
    while (d2 == 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (v_done === 1'b1) begin
        if (d1 == 0) d1 = cyc; else d2 = cyc;
        check("t5.pass", v_pass, 1);
      end
    end
    start_v = 1'b0;
    check("t5.first_done", d1, 17);
    check("t5.period", d2 - d1, 18);
    repeat (4) begin @(posedge clk); #1; end
    check("t5.idle_after", v_busy, 0);
    check("t5.minterms", v_minterms, 8'hA2);

    // Async reset while combination 5 is settling.
    @(negedge clk);
    sel = 1'b0; tbl_v = 8'hA2; exp_v = 8'hA2; start_v = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      start_v = 1'b0;
    end while (!(v_busy === 1'b1 && int'(v_in_vec) == 5) && cyc < 400);
    check("t6.reach5", (cyc < 400), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6.in_vec", a_in_vec, 0);
    check("t6.minterms", a_minterms, 0);
    check("t6.ones", a_ones, 0);
    check("t6.busy", a_busy, 0);
    check("t6.done", a_done, 0);
    check("t6.pass", a_pass, 0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    scan(1'b0, 8'hA2, 8'hA2, "t6scan");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
